cacheline_adapter: RTL and testbench
====================================

Name: cacheline_adapter

Overview:
- Sits directly downstream of the cache datapath/controller, between the cache's line-wide physical-memory port and the burst-oriented main memory.
- Converts one line read into N sequential burst beats assembled into a line.
- Converts one line write into N burst beats driven from a latched copy of the line.
- Single outstanding transaction; handshake is level request plus one-cycle response on both sides.

Parameters:
- s_line, 256, cache line width in bits (must equal the cache's s_word).
- s_burst, 64, memory burst beat width in bits; s_line/s_burst must be a power of two and at least 2.
- Derived localparams: num_beats = s_line/s_burst; s_beatidx = $clog2(num_beats); s_offset = $clog2(s_line) - 3.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- address_i  in  32  line address from cache (pmem_address)
- read_i  in  1  cache line read request, level, held until resp_o
- write_i  in  1  cache line write request, level, held until resp_o
- line_i  in  s_line  line to write (pmem_wdata)
- line_o  out  s_line  assembled read line (pmem_rdata)
- resp_o  out  1  one-cycle completion pulse to cache
- address_o  out  32  line-aligned address to memory
- read_o  out  1  burst read request to memory
- write_o  out  1  burst write request to memory
- burst_o  out  s_burst  current write beat
- burst_i  in  s_burst  read beat from memory
- resp_i  in  1  memory beat valid/accepted, one beat per cycle it is high

Behaviour:
- All outputs are registered state decodes or register contents; no combinational path from any input to any output.
- Reset: state IDLE, beat count 0, address register 0, line buffer 0. Outputs are resp_o=0, read_o=0, write_o=0, address_o=0, burst_o=0, line_o=0.
- Reset mid-transaction: same result; the transaction is abandoned with no resp_o pulse.
- States: IDLE, READ, WRITE, RESP.

IDLE:
- On read_i=1: latch address_i with bits [s_offset-1:0] forced to 0, clear count, go to READ.
- Else on write_i=1: latch the address as above, latch line_i into the buffer, clear count, go to WRITE.
- read_i and write_i together: read wins; write_i is ignored this cycle.
- resp_i in IDLE is ignored.

READ:
- read_o=1; address_o = latched address.
- Each cycle resp_i=1: buffer slice [count*s_burst +: s_burst] <= burst_i, count++.
- On the beat with count==num_beats-1: go to RESP. read_o drops in the next cycle.
- Gaps (resp_i=0 mid-burst) are legal; the FSM waits.

WRITE:
- write_o=1; burst_o = buffer slice [count*s_burst +: s_burst].
- Each cycle resp_i=1: count++.
- After the last beat: go to RESP.

RESP:
- resp_o=1 for exactly one cycle; read_o=0 and write_o=0.
- Next state is unconditionally IDLE; requests are re-sampled there. A cache that keeps its request high gets a new transaction.

Ordering, data and latency:
- Beat 0 carries line bits [s_burst-1:0]; beats go in ascending order. There is no critical-word-first.
- line_o continuously presents the buffer and holds its value until the next transaction overwrites it. A write transaction overwrites the buffer with line_i.
- Latency, back-to-back beats: request seen in IDLE at cycle T; read_o/write_o high from T+1. If beats arrive at T+1..T+num_beats, resp_o is at T+num_beats+1.
- Minimum request-to-response is num_beats+1 cycles.
- count width is s_beatidx; it wraps to 0 after the last beat and is never observable beyond it.

Decomposition:
- Add to package cache_types: enum cla_state_t {CLA_IDLE, CLA_READ, CLA_WRITE, CLA_RESP}.
- The beat-width constants are derived per instance from parameters, not placed in the package.
- One module, no sub-module. Buffer, counter and FSM are small enough to stay inline with separate state register, next-state comb, and datapath always_ff blocks.

Test Plan:
- Read, back-to-back beats: address_i=32'h1234_5678, read_i=1; memory returns 64'hA0..A3 patterns on 4 consecutive resp_i cycles -> address_o=32'h1234_5660, read_o high 4 cycles, resp_o exactly one cycle later, line_o={A3,A2,A1,A0}.
- Write: line_i=256'h{D3,D2,D1,D0}, write_i=1, resp_i high with 1-cycle gaps between beats -> burst_o steps D0,D1,D2,D3 only on resp_i edges, write_o held throughout, single resp_o after beat 3.
- Simultaneous request: read_i=1 and write_i=1 in IDLE -> READ taken, write_o never asserted, buffer not loaded from line_i.
- Reset mid-read: rst after 2 of 4 beats -> next cycle read_o=0, resp_o=0, line_o=0, count=0; a fresh read then completes normally.
- Held request: read_i kept high across resp_o -> resp_o pulse, one IDLE cycle, then a second READ with read_o reasserted. Spurious resp_i in IDLE does not alter line_o.
- Parameter sweep: s_burst=128 -> 2 beats, resp_o at T+3 with back-to-back beats.

Source files
------------

// File: rtl/cache_types.sv
// rtl/cache_types.sv - shared cache type definitions
package cache_types;

  typedef enum logic [1:0] {
    CLA_IDLE,
    CLA_READ,
    CLA_WRITE,
    CLA_RESP
  } cla_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// rtl/cacheline_adapter.sv - cache line to memory burst adapter
module cacheline_adapter
  import cache_types::*;
#(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  output logic               resp_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  output logic [s_burst-1:0] burst_o,
  input  logic [s_burst-1:0] burst_i,
  input  logic               resp_i
);

  localparam int num_beats = s_line / s_burst;
  localparam int s_beatidx = $clog2(num_beats);
  localparam int s_offset  = $clog2(s_line) - 3;
  localparam logic [s_beatidx-1:0] last_beat = s_beatidx'(num_beats - 1);
  localparam logic [31:0] line_mask = ~((32'd1 << s_offset) - 32'd1);

  cla_state_t state_q, state_d;
  logic [s_beatidx-1:0]              count_q;
  logic [31:0]                       addr_q;
  logic [num_beats-1:0][s_burst-1:0] buf_q;
  logic                              last_beat_seen;

  assign last_beat_seen = resp_i && (count_q == last_beat);

  always_ff @(posedge clk) begin
    if (rst) state_q <= CLA_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLA_IDLE: begin
        // read wins when both requests are raised together
        if (read_i)       state_d = CLA_READ;
        else if (write_i) state_d = CLA_WRITE;
      end
      CLA_READ, CLA_WRITE: begin
        if (last_beat_seen) state_d = CLA_RESP;
      end
      CLA_RESP: state_d = CLA_IDLE;
      default:  state_d = CLA_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
    end else begin
      case (state_q)
        CLA_IDLE: begin
          if (read_i || write_i) begin
            addr_q  <= address_i & line_mask;
            count_q <= '0;
            if (!read_i) buf_q <= line_i;
          end
        end
        CLA_READ: begin
          if (resp_i) begin
            buf_q[count_q] <= burst_i;
            count_q        <= count_q + 1'b1;
          end
        end
        CLA_WRITE: begin
          if (resp_i) count_q <= count_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign read_o    = (state_q == CLA_READ);
  assign write_o   = (state_q == CLA_WRITE);
  assign resp_o    = (state_q == CLA_RESP);
  assign address_o = addr_q;
  assign line_o    = buf_q;
  assign burst_o   = buf_q[count_q];

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb/tb_cacheline_adapter.sv - randomized self-checking bench for cacheline_adapter
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address_i;
  logic         read_i, write_i;
  logic [255:0] line_i, line_o;
  logic         resp_o, read_o, write_o, resp_i;
  logic [31:0]  address_o;
  logic [63:0]  burst_o, burst_i;

  logic [31:0]  b_address_i, b_address_o;
  logic         b_read_i, b_write_i, b_resp_o, b_read_o, b_write_o, b_resp_i;
  logic [255:0] b_line_i, b_line_o;
  logic [127:0] b_burst_o, b_burst_i;

  int n_cmp = 0;
  int n_err = 0;

  // memory model: whole lines keyed by line-aligned address
  logic [255:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  cacheline_adapter dut (
    .clk(clk), .rst(rst), .address_i(address_i), .read_i(read_i), .write_i(write_i),
    .line_i(line_i), .line_o(line_o), .resp_o(resp_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
  );

  cacheline_adapter #(.s_line(256), .s_burst(128)) dut_b (
    .clk(clk), .rst(rst), .address_i(b_address_i), .read_i(b_read_i), .write_i(b_write_i),
    .line_i(b_line_i), .line_o(b_line_o), .resp_o(b_resp_o), .address_o(b_address_o),
    .read_o(b_read_o), .write_o(b_write_o), .burst_o(b_burst_o), .burst_i(b_burst_i),
    .resp_i(b_resp_i)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic bit take_gap(input int gap_mode);
    return (gap_mode == 2) || (gap_mode == 1 && $urandom_range(0, 1) == 1);
  endfunction

  // called at a negedge; returns at the negedge after the resp_o cycle
  task automatic do_read(input logic [31:0] a, input int gap_mode, input bit keep, input bit also_write);
    logic [31:0]  al;
    logic [255:0] exp;
    int cyc;
    bit gapped;
    al = a & ~32'h1f;
    if (!mem.exists(al)) mem[al] = rand_line();
    exp = mem[al];
    address_i = a; read_i = 1'b1; write_i = also_write; line_i = rand_line(); resp_i = 1'b0;
    @(negedge clk);
    cyc = 1; gapped = 1'b0;
    check_eq("rd_req", read_o, 1'b1);
    check_eq("rd_addr", address_o, al);
    check_eq("rd_no_wr", write_o, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (take_gap(gap_mode)) begin
        resp_i = 1'b0; burst_i = {$urandom, $urandom};
        @(negedge clk);
        cyc++; gapped = 1'b1;
        check_eq("rd_gap_hold", read_o, 1'b1);
        check_eq("rd_gap_noresp", resp_o, 1'b0);
      end
      resp_i = 1'b1; burst_i = exp[k*64 +: 64];
      @(negedge clk);
      cyc++;
      if (k < 3) check_eq("rd_beat_hold", read_o, 1'b1);
    end
    check_eq("rd_resp", resp_o, 1'b1);
    check_eq("rd_drop", read_o, 1'b0);
    check_eq("rd_no_wr2", write_o, 1'b0);
    check_eq("rd_line", line_o, exp);
    if (!gapped) check_eq("rd_latency", cyc, 5);
    resp_i = 1'b0;
    if (!keep) begin read_i = 1'b0; write_i = 1'b0; end
    @(negedge clk);
    check_eq("rd_resp_1cyc", resp_o, 1'b0);
    check_eq("rd_idle", read_o, 1'b0);
  endtask

  task automatic do_write(input logic [31:0] a, input int gap_mode);
    logic [31:0]  al;
    logic [255:0] data;
    al = a & ~32'h1f;
    data = rand_line();
    address_i = a; write_i = 1'b1; read_i = 1'b0; line_i = data; resp_i = 1'b0;
    @(negedge clk);
    line_i = rand_line();
    check_eq("wr_req", write_o, 1'b1);
    check_eq("wr_no_rd", read_o, 1'b0);
    check_eq("wr_addr", address_o, al);
    for (int k = 0; k < 4; k++) begin
      check_eq("wr_beat", burst_o, data[k*64 +: 64]);
      if (take_gap(gap_mode)) begin
        resp_i = 1'b0;
        @(negedge clk);
        check_eq("wr_gap_hold", write_o, 1'b1);
        check_eq("wr_gap_beat", burst_o, data[k*64 +: 64]);
      end
      resp_i = 1'b1;
      @(negedge clk);
      if (k < 3) check_eq("wr_beat_hold", write_o, 1'b1);
    end
    mem[al] = data;
    check_eq("wr_resp", resp_o, 1'b1);
    check_eq("wr_drop", write_o, 1'b0);
    check_eq("wr_line", line_o, data);
    resp_i = 1'b0; write_i = 1'b0;
    @(negedge clk);
    check_eq("wr_resp_1cyc", resp_o, 1'b0);
    check_eq("wr_idle", write_o, 1'b0);
  endtask

  initial begin
    logic [31:0]  al;
    logic [255:0] old_line, bl;
    int cyc;

    rst = 1'b1;
    address_i = '0; read_i = 1'b0; write_i = 1'b0; line_i = '0; burst_i = '0; resp_i = 1'b0;
    b_address_i = '0; b_read_i = 1'b0; b_write_i = 1'b0; b_line_i = '0; b_burst_i = '0; b_resp_i = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_resp", resp_o, 1'b0);
    check_eq("rst_read", read_o, 1'b0);
    check_eq("rst_write", write_o, 1'b0);
    check_eq("rst_addr", address_o, 32'h0);
    check_eq("rst_burst", burst_o, 64'h0);
    check_eq("rst_line", line_o, 256'h0);
    check_eq("rst_b_line", b_line_o, 256'h0);
    rst = 1'b0;

    // directed read with ascending A0..A3 beats
    mem[32'h1234_5660] = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
                          64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
    do_read(32'h1234_5678, 0, 1'b0, 1'b0);

    do_write(32'h0000_2010, 2);
    do_read(32'h0000_2004, 0, 1'b0, 1'b0);

    // both requests raised: read must win and the buffer must not take line_i
    do_read(32'h0000_3000, 1, 1'b0, 1'b1);

    // reset after two of four read beats
    al = 32'h0000_4000;
    address_i = al; read_i = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
      @(negedge clk);
    end
    rst = 1'b1; read_i = 1'b0; resp_i = 1'b0;
    @(negedge clk);
    check_eq("mrst_read", read_o, 1'b0);
    check_eq("mrst_resp", resp_o, 1'b0);
    check_eq("mrst_line", line_o, 256'h0);
    check_eq("mrst_addr", address_o, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mrst_no_resp", resp_o, 1'b0);
    do_read(32'h0000_4008, 0, 1'b0, 1'b0);

    // held read request with a spurious resp_i in the IDLE cycle
    al = 32'h0000_5000;
    do_read(al, 0, 1'b1, 1'b0);
    old_line = mem[al];
    mem[al] = rand_line();
    resp_i = 1'b1; burst_i = {$urandom, $urandom};
    @(negedge clk);
    check_eq("held_reissue", read_o, 1'b1);
    check_eq("held_line_kept", line_o, old_line);
    do_read(al, 2, 1'b0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      al = 32'h8000_0000 + 32'($urandom_range(0, 3)) * 32 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) do_write(al, $urandom_range(0, 1));
      else do_read(al, $urandom_range(0, 1), 1'b0, 1'($urandom_range(0, 1)));
    end

    // two-beat instance
    bl = rand_line();
    b_address_i = 32'h0000_1234; b_read_i = 1'b1;
    @(negedge clk);
    cyc = 1;
    check_eq("b_read", b_read_o, 1'b1);
    check_eq("b_addr", b_address_o, 32'h0000_1220);
    for (int k = 0; k < 2; k++) begin
      b_resp_i = 1'b1; b_burst_i = bl[k*128 +: 128];
      @(negedge clk);
      cyc++;
    end
    check_eq("b_resp", b_resp_o, 1'b1);
    check_eq("b_latency", cyc, 3);
    check_eq("b_line", b_line_o, bl);
    b_read_i = 1'b0; b_resp_i = 1'b0;
    @(negedge clk);
    check_eq("b_resp_1cyc", b_resp_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
